// File: rtl/gardner_pkg.sv
// Shared types and constants for the Gardner symbol-timing loop.
// Holds the loop state enum, integrator/accumulator widths and slip threshold.
package gardner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    localparam int INTEG_W = 24;
    localparam int ACC_W   = 25;
    localparam int SLIP_TH = 32768;

    localparam logic signed [ACC_W-1:0] INTEG_MAX =
        ACC_W'((1 <<< (INTEG_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] INTEG_MIN = -INTEG_MAX;
    localparam logic signed [ACC_W-1:0] SLIP_POS  = ACC_W'(SLIP_TH);
    localparam logic signed [ACC_W-1:0] SLIP_NEG  = -SLIP_POS;

endpackage

// File: rtl/gardner_timing_ctrl_if.sv
// Handshake bundle between the timing loop and its neighbours.
// master drives control and error; slave returns strobe, lock and slip status.
interface gardner_timing_ctrl_if #(
    parameter int WIDTH = 16
);

    logic                    enable;
    logic                    is_bpsk;
    logic signed [WIDTH-1:0] error_n;
    logic                    sym_strobe;
    logic                    locked;
    logic                    slip_adv;
    logic                    slip_ret;
    logic [15:0]             slip_adv_cnt;
    logic [15:0]             slip_ret_cnt;

    modport master (
        output enable, is_bpsk, error_n,
        input  sym_strobe, locked, slip_adv, slip_ret,
        input  slip_adv_cnt, slip_ret_cnt
    );

    modport slave (
        input  enable, is_bpsk, error_n,
        output sym_strobe, locked, slip_adv, slip_ret,
        output slip_adv_cnt, slip_ret_cnt
    );

endinterface

// File: rtl/gardner_loop_filter.sv
// PI loop filter: saturating 24-bit integrator plus proportional path.
// ctrl is combinational from err and the integrator value after this update.
module gardner_loop_filter
    import gardner_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int KP_SHIFT = 4,
    parameter int KI_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    update,
    input  logic                    track,
    input  logic signed [WIDTH-1:0] err,
    output logic signed [ACC_W-1:0] ctrl
);

    logic signed [INTEG_W-1:0] integ;
    logic signed [INTEG_W-1:0] integ_nxt;
    logic signed [WIDTH-1:0]   err_i;
    logic signed [WIDTH-1:0]   err_p;
    logic signed [ACC_W-1:0]   isum;

    // Gain select, integrator saturation and proportional sum
    always_comb begin
        err_i = track ? (err >>> (KI_SHIFT + 4)) : (err >>> KI_SHIFT);
        err_p = track ? (err >>> (KP_SHIFT + 2)) : (err >>> KP_SHIFT);
        isum  = {integ[INTEG_W-1], integ}
              + {{(ACC_W-WIDTH){err_i[WIDTH-1]}}, err_i};
        if (isum > INTEG_MAX)
            integ_nxt = INTEG_MAX[INTEG_W-1:0];
        else if (isum < INTEG_MIN)
            integ_nxt = INTEG_MIN[INTEG_W-1:0];
        else
            integ_nxt = isum[INTEG_W-1:0];
        ctrl = {integ_nxt[INTEG_W-1], integ_nxt}
             + {{(ACC_W-WIDTH){err_p[WIDTH-1]}}, err_p};
    end

    // Integrator register, cleared on restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            integ <= '0;
        else if (clear)
            integ <= '0;
        else if (update)
            integ <= integ_nxt;
    end

endmodule

// File: rtl/gardner_timing_ctrl.sv
// Gardner symbol-timing controller: phase counter, lock FSM, slip logic.
// GARDNER_TIMING_CTRL_STATS_EN builds saturating slip counters.
module gardner_timing_ctrl
    import gardner_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int SPS          = 32,
    parameter int ERR_LAT      = 2,
    parameter int KP_SHIFT     = 4,
    parameter int KI_SHIFT     = 10,
    parameter int LOCK_THRESH  = 512,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 8
) (
    input  logic clk_32M768,
    input  logic rst_n,
    gardner_timing_ctrl_if.slave bus
);

    localparam int CNT_W   = $clog2(SPS);
    localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPS - 1);
    localparam logic [CNT_W-1:0] CNT_SKIP  = CNT_W'(2);
    localparam logic [RUN_W-1:0] GOOD_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0] GOOD_MAX  = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] BAD_LAST  = RUN_W'(UNLOCK_COUNT - 1);
    localparam logic [RUN_W-1:0] BAD_MAX   = RUN_W'(UNLOCK_COUNT);
    localparam logic [WIDTH:0]   TH_GOOD   = (WIDTH + 1)'(LOCK_THRESH);
    localparam logic [WIDTH:0]   TH_BAD    = (WIDTH + 1)'(2 * LOCK_THRESH);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [ERR_LAT-1:0]      sd;
    logic                    run, wrap, chg, upd, dec;
    logic                    bpsk_q;
    logic                    adv_skip, ret_hold;
    logic                    pend_adv, pend_ret;
    logic                    strobe_q, locked_q;
    logic                    slip_adv_q, slip_ret_q;
    logic [RUN_W-1:0]        good_cnt, bad_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ctrl;
    logic signed [WIDTH:0]   err_x;
    logic [WIDTH:0]          mag;
    logic                    good, bad;

    assign run  = bus.enable && (state != IDLE);
    assign wrap = run && (cnt == CNT_LAST);
    assign chg  = bus.is_bpsk != bpsk_q;
    assign upd  = run && sd[ERR_LAT-1];

    // Classify the error sample by magnitude for lock tracking
    always_comb begin
        err_x = {bus.error_n[WIDTH-1], bus.error_n};
        mag   = err_x[WIDTH] ? -err_x : err_x;
        good  = mag < TH_GOOD;
        bad   = mag >= TH_BAD;
    end

    // Next phase: skip 1 on advance, repeat 0 on retard
    always_comb begin
        cnt_nxt = '0;
        if (!run)
            cnt_nxt = '0;
        else if (cnt == '0 && adv_skip)
            cnt_nxt = CNT_SKIP;
        else if (cnt == '0 && ret_hold)
            cnt_nxt = '0;
        else if (cnt == CNT_LAST)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + 1'b1;
    end

    gardner_loop_filter #(
        .WIDTH   (WIDTH),
        .KP_SHIFT(KP_SHIFT),
        .KI_SHIFT(KI_SHIFT)
    ) u_filt (
        .clk   (clk_32M768),
        .rst_n (rst_n),
        .clear (!bus.enable || chg),
        .update(upd),
        .track (state == TRACK),
        .err   (bus.error_n),
        .ctrl  (ctrl)
    );

    // Phase counter, lock FSM, accumulator and slip scheduling
    always_ff @(posedge clk_32M768 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sd         <= '0;
            dec        <= 1'b0;
            bpsk_q     <= 1'b0;
            adv_skip   <= 1'b0;
            ret_hold   <= 1'b0;
            pend_adv   <= 1'b0;
            pend_ret   <= 1'b0;
            strobe_q   <= 1'b0;
            locked_q   <= 1'b0;
            slip_adv_q <= 1'b0;
            slip_ret_q <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            acc        <= '0;
        end else begin
            bpsk_q     <= bus.is_bpsk;
            cnt        <= cnt_nxt;
            strobe_q   <= run && (cnt_nxt == CNT_LAST);
            dec        <= upd;
            slip_adv_q <= 1'b0;
            slip_ret_q <= 1'b0;
            for (int i = ERR_LAT - 1; i > 0; i--)
                sd[i] <= sd[i-1];
            sd[0] <= strobe_q;
            if (run && cnt == '0) begin
                adv_skip <= 1'b0;
                ret_hold <= 1'b0;
            end
            if (!bus.enable) begin
                state    <= IDLE;
                locked_q <= 1'b0;
                acc      <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
                pend_adv <= 1'b0;
                pend_ret <= 1'b0;
                adv_skip <= 1'b0;
                ret_hold <= 1'b0;
                sd       <= '0;
                dec      <= 1'b0;
            end else if (chg) begin
                acc      <= '0;
                pend_adv <= 1'b0;
                pend_ret <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
                locked_q <= 1'b0;
                if (state != IDLE)
                    state <= ACQUIRE;
            end else begin
                if (state == IDLE)
                    state <= ACQUIRE;
                if (upd) begin
                    acc <= acc + ctrl;
                    if (good) begin
                        bad_cnt <= '0;
                        if (state == ACQUIRE && good_cnt == GOOD_LAST) begin
                            state    <= TRACK;
                            locked_q <= 1'b1;
                            good_cnt <= '0;
                        end else if (good_cnt != GOOD_MAX) begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end else if (bad) begin
                        good_cnt <= '0;
                        if (state == TRACK && bad_cnt == BAD_LAST) begin
                            state    <= ACQUIRE;
                            locked_q <= 1'b0;
                            bad_cnt  <= '0;
                        end else if (bad_cnt != BAD_MAX) begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end else begin
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                end
                if (dec && !pend_adv && !pend_ret) begin
                    if (acc >= SLIP_POS) begin
                        pend_adv <= 1'b1;
                        acc      <= acc - SLIP_POS;
                    end else if (acc <= SLIP_NEG) begin
                        pend_ret <= 1'b1;
                        acc      <= acc + SLIP_POS;
                    end
                end
                if (wrap && pend_adv) begin
                    pend_adv   <= 1'b0;
                    adv_skip   <= 1'b1;
                    slip_adv_q <= 1'b1;
                end else if (wrap && pend_ret) begin
                    pend_ret   <= 1'b0;
                    ret_hold   <= 1'b1;
                    slip_ret_q <= 1'b1;
                end
            end
        end
    end

    assign bus.sym_strobe = strobe_q;
    assign bus.locked     = locked_q;
    assign bus.slip_adv   = slip_adv_q;
    assign bus.slip_ret   = slip_ret_q;

`ifdef GARDNER_TIMING_CTRL_STATS_EN
    logic [15:0] adv_cnt;
    logic [15:0] ret_cnt;

    // Saturating slip tallies, cleared only by reset
    always_ff @(posedge clk_32M768 or negedge rst_n) begin
        if (!rst_n) begin
            adv_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (slip_adv_q && adv_cnt != 16'hFFFF)
                adv_cnt <= adv_cnt + 1'b1;
            if (slip_ret_q && ret_cnt != 16'hFFFF)
                ret_cnt <= ret_cnt + 1'b1;
        end
    end

    assign bus.slip_adv_cnt = adv_cnt;
    assign bus.slip_ret_cnt = ret_cnt;
`else
    assign bus.slip_adv_cnt = '0;
    assign bus.slip_ret_cnt = '0;
`endif

endmodule

// File: tb/tb_gardner_timing_ctrl.sv
// Directed bench for gardner_timing_ctrl with hand-computed loop values.
// Slip-counter expectations follow GARDNER_TIMING_CTRL_STATS_EN.
module tb_gardner_timing_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gardner_timing_ctrl_if #(.WIDTH(16)) bus ();

    gardner_timing_ctrl #(
        .WIDTH       (16),
        .SPS         (32),
        .ERR_LAT     (2),
        .KP_SHIFT    (4),
        .KI_SHIFT    (10),
        .LOCK_THRESH (512),
        .LOCK_COUNT  (64),
        .UNLOCK_COUNT(8)
    ) dut (
        .clk_32M768(clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

`ifdef GARDNER_TIMING_CTRL_STATS_EN
    localparam int EXP_SLIP_CNT = 1;
`else
    localparam int EXP_SLIP_CNT = 0;
`endif

    task automatic do_reset();
        bus.enable  = 1'b0;
        bus.is_bpsk = 1'b0;
        bus.error_n = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sym_strobe && n < budget);
        if (!bus.sym_strobe) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout waited %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        logic [35:0] v;
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.is_bpsk = 1'b0;
        bus.error_n = 16'sh7FFF;
        repeat (2) @(negedge clk);
        v = {bus.sym_strobe, bus.locked, bus.slip_adv, bus.slip_ret,
             bus.slip_adv_cnt, bus.slip_ret_cnt};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", v);
        end
        rst_n = 1'b1;
        wait_strobe(40, n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL first_strobe got %0d want 32", n);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut.cnt !== '0) begin
            errors++;
            $display("FAIL async_cnt got %0d want 0", dut.cnt);
        end
        v = {bus.sym_strobe, bus.locked, bus.slip_adv, bus.slip_ret,
             bus.slip_adv_cnt, bus.slip_ret_cnt};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL async_outputs got %h want 0", v);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(40, n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL restart_strobe got %0d want 32", n);
        end
    endtask

    task automatic test_zero_error();
        int ns = 0, last = 0, badp = 0, slips = 0;
        int s64 = -1, lock_t = -1, falls = 0;
        logic lk_prev = 1'b0;
        do_reset();
        bus.enable = 1'b1;
        for (int t = 1; t <= 10000; t++) begin
            @(negedge clk);
            if (bus.sym_strobe) begin
                ns++;
                if (ns > 1 && t - last != 32)
                    badp++;
                last = t;
                if (ns == 64)
                    s64 = t;
            end
            if (bus.slip_adv || bus.slip_ret)
                slips++;
            if (bus.locked && !lk_prev && lock_t < 0)
                lock_t = t;
            if (!bus.locked && lk_prev)
                falls++;
            lk_prev = bus.locked;
        end
        checks++;
        if (ns != 312) begin
            errors++;
            $display("FAIL zero_strobe_count got %0d want 312", ns);
        end
        checks++;
        if (badp != 0) begin
            errors++;
            $display("FAIL zero_period got %0d bad periods want 0", badp);
        end
        checks++;
        if (slips != 0) begin
            errors++;
            $display("FAIL zero_slips got %0d want 0", slips);
        end
        checks++;
        if (s64 < 0 || lock_t != s64 + 3) begin
            errors++;
            $display("FAIL zero_lock_time got %0d want %0d", lock_t, s64 + 3);
        end
        checks++;
        if (falls != 0) begin
            errors++;
            $display("FAIL zero_lock_drop got %0d want 0", falls);
        end
    endtask

    task automatic test_slip(input bit adv);
        int st[0:99];
        int ns = 0, slip_t = -1, other = 0, badp = 0, t = 0;
        int per, cnt_same, cnt_other;
        do_reset();
        bus.error_n = adv ? 16'sd4096 : -16'sd4096;
        bus.enable = 1'b1;
        while (ns < 81 && t < 3500) begin
            @(negedge clk);
            t++;
            if (bus.sym_strobe) begin
                ns++;
                st[ns] = t;
                if (ns > 1 && ns <= 80 && st[ns] - st[ns-1] != 32)
                    badp++;
            end
            if ((adv ? bus.slip_adv : bus.slip_ret) && slip_t < 0)
                slip_t = t;
            if (adv ? bus.slip_ret : bus.slip_adv)
                other++;
        end
        checks++;
        if (ns < 81) begin
            errors++;
            $display("FAIL slip_strobes adv=%0d got %0d want 81", adv, ns);
        end else begin
            checks++;
            if (slip_t != st[80] + 1) begin
                errors++;
                $display("FAIL slip_time adv=%0d got %0d want %0d",
                         adv, slip_t, st[80] + 1);
            end
            per = st[81] - st[80];
            checks++;
            if (per != (adv ? 31 : 33)) begin
                errors++;
                $display("FAIL slip_period adv=%0d got %0d want %0d",
                         adv, per, adv ? 31 : 33);
            end
        end
        checks++;
        if (badp != 0 || other != 0) begin
            errors++;
            $display("FAIL slip_clean adv=%0d got bad=%0d other=%0d want 0 0",
                     adv, badp, other);
        end
        @(negedge clk);
        cnt_same  = adv ? bus.slip_adv_cnt : bus.slip_ret_cnt;
        cnt_other = adv ? bus.slip_ret_cnt : bus.slip_adv_cnt;
        checks++;
        if (cnt_same != EXP_SLIP_CNT || cnt_other != 0) begin
            errors++;
            $display("FAIL slip_count adv=%0d got %0d/%0d want %0d/0",
                     adv, cnt_same, cnt_other, EXP_SLIP_CNT);
        end
    endtask

    task automatic test_lock_unlock();
        int n, a, ig;
        do_reset();
        bus.error_n = 16'sd100;
        bus.enable = 1'b1;
        for (int k = 0; k < 64; k++)
            wait_strobe(40, n);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early got %b want 0", bus.locked);
        end
        @(negedge clk);
        a = dut.acc;
        ig = dut.u_filt.integ;
        checks++;
        if (bus.locked !== 1'b1 || a != 384 || ig != 0) begin
            errors++;
            $display("FAIL lock_rise got lk=%b acc=%0d integ=%0d want 1 384 0",
                     bus.locked, a, ig);
        end
        bus.error_n = 16'sd2000;
        for (int k = 0; k < 8; k++)
            wait_strobe(40, n);
        repeat (2) @(negedge clk);
        a = dut.acc;
        checks++;
        if (bus.locked !== 1'b1 || a != 601) begin
            errors++;
            $display("FAIL track_gain got lk=%b acc=%0d want 1 601",
                     bus.locked, a);
        end
        @(negedge clk);
        a = dut.acc;
        checks++;
        if (bus.locked !== 1'b0 || a != 632) begin
            errors++;
            $display("FAIL unlock got lk=%b acc=%0d want 0 632", bus.locked, a);
        end
        wait_strobe(40, n);
        repeat (3) @(negedge clk);
        a = dut.acc;
        ig = dut.u_filt.integ;
        checks++;
        if (a != 758 || ig != 1) begin
            errors++;
            $display("FAIL acq_gain got acc=%0d integ=%0d want 758 1", a, ig);
        end
    endtask

    task automatic test_bpsk_toggle();
        int n, a, ig;
        do_reset();
        bus.error_n = -16'sd100;
        bus.enable = 1'b1;
        for (int k = 0; k < 64; k++)
            wait_strobe(40, n);
        repeat (3) @(negedge clk);
        a = dut.acc;
        ig = dut.u_filt.integ;
        checks++;
        if (bus.locked !== 1'b1 || a != -2528 || ig != -64) begin
            errors++;
            $display("FAIL bpsk_pre got lk=%b acc=%0d integ=%0d want 1 -2528 -64",
                     bus.locked, a, ig);
        end
        repeat (7) @(negedge clk);
        bus.is_bpsk = 1'b1;
        @(negedge clk);
        a = dut.acc;
        ig = dut.u_filt.integ;
        checks++;
        if (bus.locked !== 1'b0 || a != 0 || ig != 0) begin
            errors++;
            $display("FAIL bpsk_clear got lk=%b acc=%0d integ=%0d want 0 0 0",
                     bus.locked, a, ig);
        end
        wait_strobe(40, n);
        checks++;
        if (n != 21) begin
            errors++;
            $display("FAIL bpsk_cadence got %0d want 21", n);
        end
    endtask

    task automatic test_disable();
        int n, a, ns = 0;
        do_reset();
        bus.error_n = 16'sd100;
        bus.enable = 1'b1;
        for (int k = 0; k < 3; k++)
            wait_strobe(40, n);
        repeat (3) @(negedge clk);
        a = dut.acc;
        checks++;
        if (a != 18) begin
            errors++;
            $display("FAIL dis_pre_acc got %0d want 18", a);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        a = dut.acc;
        checks++;
        if (a != 0 || dut.cnt !== '0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL dis_clear got acc=%0d cnt=%0d lk=%b want 0 0 0",
                     a, dut.cnt, bus.locked);
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.sym_strobe)
                ns++;
        end
        checks++;
        if (ns != 0) begin
            errors++;
            $display("FAIL dis_strobes got %0d want 0", ns);
        end
        bus.enable = 1'b1;
        wait_strobe(40, n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL reenable_strobe got %0d want 32", n);
        end
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.is_bpsk = 1'b0;
        bus.error_n = '0;
        test_reset();
        test_zero_error();
        test_slip(1'b1);
        test_slip(1'b0);
        test_lock_unlock();
        test_bpsk_toggle();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
